// File: rtl/edf_task_scheduler.sv
// Earliest-deadline-first task scheduler: NUM_TASKS pending slots, wrap-safe
// deadline ordering, registered valid/ready dispatch and lateness flag.
module edf_task_scheduler #(
  parameter int NUM_TASKS  = 8,
  parameter int ID_W       = 8,
  parameter int TIME_W     = 16,
  parameter int DEADLINE_W = 12,
  parameter int MODE       = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ID_W-1:0]                in_id,
  input  logic [DEADLINE_W-1:0]          in_deadline,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ID_W-1:0]                out_id,
  output logic [TIME_W-1:0]              out_deadline,
  output logic                           out_late,
  output logic [$clog2(NUM_TASKS+1)-1:0] count,
  output logic                           full,
  output logic                           empty,
  output logic [TIME_W-1:0]              now
);

  localparam int CNT_W = $clog2(NUM_TASKS + 1);
  localparam int IDX_W = $clog2(NUM_TASKS);

  if (DEADLINE_W > TIME_W - 1) begin : g_deadline_w_check
    $error("edf_task_scheduler: DEADLINE_W must not exceed TIME_W-1");
  end

  // a earlier than b when (a - b) is negative as a TIME_W-bit signed value
  function automatic logic earlier(input logic [TIME_W-1:0] a, input logic [TIME_W-1:0] b);
    logic [TIME_W-1:0] diff;
    diff = a - b;
    return diff[TIME_W-1];
  endfunction

  logic [TIME_W-1:0]    now_q;
  logic [NUM_TASKS-1:0] slot_valid_q, slot_valid_d;
  logic [ID_W-1:0]      slot_id_q [NUM_TASKS];
  logic [TIME_W-1:0]    slot_dl_q [NUM_TASKS];
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 out_valid_q;
  logic [ID_W-1:0]      out_id_q;
  logic [TIME_W-1:0]    out_deadline_q;

  logic                 sel_found_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic [TIME_W-1:0]    sel_dl_s;
  logic [IDX_W-1:0]     free_idx_s;
  logic                 eligible_s, load_s, accept_s;
  logic [TIME_W-1:0]    abs_dl_s;

  // Earliest valid deadline; strict compare keeps the lowest index on ties
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    sel_dl_s    = '0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      if (slot_valid_q[i] && (!sel_found_s || earlier(slot_dl_q[i], sel_dl_s))) begin
        sel_found_s = 1'b1;
        sel_idx_s   = IDX_W'(i);
        sel_dl_s    = slot_dl_q[i];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Lowest-index free slot, from pre-edge occupancy only
  always_comb begin
    free_idx_s = '0;
    for (int i = NUM_TASKS - 1; i >= 0; i--) begin
      if (!slot_valid_q[i]) begin
        free_idx_s = IDX_W'(i);
      end else begin
        free_idx_s = free_idx_s;
      end
    end
  end

  assign full       = (count_q == CNT_W'(NUM_TASKS));
  assign empty      = (count_q == CNT_W'(0));
  assign in_ready   = !full;
  assign accept_s   = in_valid && !full;
  assign abs_dl_s   = now_q + TIME_W'(1) + TIME_W'(in_deadline);
  assign eligible_s = sel_found_s && ((MODE != 0) || !earlier(now_q, sel_dl_s));
  assign load_s     = eligible_s && (!out_valid_q || out_ready);

  // Slot occupancy and count after this edge's load and accept
  always_comb begin
    slot_valid_d = slot_valid_q;
    if (load_s) begin
      slot_valid_d[sel_idx_s] = 1'b0;
    end else begin
      slot_valid_d = slot_valid_d;
    end
    if (accept_s) begin
      slot_valid_d[free_idx_s] = 1'b1;
    end else begin
      slot_valid_d = slot_valid_d;
    end
    count_d = count_q + CNT_W'(accept_s) - CNT_W'(load_s);
  end

  // Control state: time base, occupancy and output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      now_q          <= '0;
      slot_valid_q   <= '0;
      count_q        <= '0;
      out_valid_q    <= 1'b0;
      out_id_q       <= '0;
      out_deadline_q <= '0;
    end else begin
      now_q        <= now_q + TIME_W'(1);
      slot_valid_q <= slot_valid_d;
      count_q      <= count_d;
      if (load_s) begin
        out_valid_q    <= 1'b1;
        out_id_q       <= slot_id_q[sel_idx_s];
        out_deadline_q <= sel_dl_s;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= out_valid_q;
      end
    end
  end

  // Slot payload; meaningful only while the matching valid bit is set
  always_ff @(posedge clk) begin
    if (accept_s) begin
      slot_id_q[free_idx_s] <= in_id;
      slot_dl_q[free_idx_s] <= abs_dl_s;
    end else begin
      slot_id_q[free_idx_s] <= slot_id_q[free_idx_s];
    end
  end

  assign out_valid    = out_valid_q;
  assign out_id       = out_id_q;
  assign out_deadline = out_deadline_q;
  assign count        = count_q;
  assign now          = now_q;
  // A task released at its deadline is presented one cycle later, so late means
  // the deadline precedes the cycle in which the register could have loaded it.
  assign out_late     = out_valid_q && earlier(out_deadline_q, now_q - TIME_W'(1));

endmodule

// File: tb/tb_edf_task_scheduler.sv
// Bench for edf_task_scheduler: a default MODE 0 instance and a MODE 1 instance
// with an 8-bit time base, both scored against a deadline-rule reference model.
module tb_edf_task_scheduler;
  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rstn = 2'b00;
  logic [1:0]       iv   = 2'b00;
  logic [1:0]       ordy = 2'b00;
  logic [1:0][7:0]  iid  = '0;
  logic [1:0][11:0] idl  = '0;

  wire [1:0]        ov, olate, fl, em, irdy;
  wire [1:0][7:0]   oid;
  wire [1:0][15:0]  odl, nw;
  wire [1:0][3:0]   cnt;

  assign odl[1][15:8] = 8'h00;
  assign nw[1][15:8]  = 8'h00;

  edf_task_scheduler u0 (
    .clk(clk), .reset_n(rstn[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_id(iid[0]), .in_deadline(idl[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_id(oid[0]), .out_deadline(odl[0]), .out_late(olate[0]), .count(cnt[0]),
    .full(fl[0]), .empty(em[0]), .now(nw[0])
  );

  edf_task_scheduler #(.NUM_TASKS(8), .ID_W(8), .TIME_W(8), .DEADLINE_W(7), .MODE(1)) u1 (
    .clk(clk), .reset_n(rstn[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_id(iid[1]), .in_deadline(idl[1][6:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_id(oid[1]), .out_deadline(odl[1][7:0]), .out_late(olate[1]), .count(cnt[1]),
    .full(fl[1]), .empty(em[1]), .now(nw[1][7:0])
  );

  typedef struct { int id; int dl; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   log1[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: pending tasks by slot, output register, time
  int mv [2][N];
  int mid [2][N];
  int mdl [2][N];
  int mnow [2];
  int mov [2];
  int moid [2];
  int modl [2];

  function automatic int msk(int k);
    return (k == 0) ? 32'h0000_FFFF : 32'h0000_00FF;
  endfunction

  // signed distance a - b on the instance's time circle
  function automatic int sdist(int k, int a, int b);
    int d;
    d = (a - b) & msk(k);
    if (d > (msk(k) >> 1)) d = d - (msk(k) + 1);
    return d;
  endfunction

  task automatic check(int k, string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s actual=%0d required=%0d at t=%0t", k, name, act, exp, $time);
    end
  endtask

  task automatic model_reset(int k);
    for (int i = 0; i < N; i++) mv[k][i] = 0;
    mnow[k] = 0; mov[k] = 0; moid[k] = 0; modl[k] = 0;
    if (k == 0) q0.delete(); else q1.delete();
  endtask

  task automatic model_step(int k);
    int best, freei, occ;
    bit acc, ld;
    exp_t e;
    best = -1; freei = -1; occ = 0;
    for (int i = 0; i < N; i++) begin
      if (mv[k][i] != 0) begin
        occ++;
        if (best < 0 || sdist(k, mdl[k][i], mdl[k][best]) < 0) best = i;
      end else if (freei < 0) begin
        freei = i;
      end
    end
    acc = iv[k] && (occ < N);
    ld  = (best >= 0) && (k == 1 || sdist(k, mdl[k][best], mnow[k]) <= 0)
          && (mov[k] == 0 || ordy[k]);
    if (ld) begin
      mov[k] = 1; moid[k] = mid[k][best]; modl[k] = mdl[k][best]; mv[k][best] = 0;
      e.id = moid[k]; e.dl = modl[k];
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end else if (ordy[k]) begin
      mov[k] = 0;
    end
    if (acc) begin
      mv[k][freei] = 1; mid[k][freei] = iid[k];
      mdl[k][freei] = (mnow[k] + 1 + idl[k]) & msk(k);
    end
    mnow[k] = (mnow[k] + 1) & msk(k);
  endtask

  always @(posedge clk or negedge rstn[0]) if (!rstn[0]) model_reset(0); else model_step(0);
  always @(posedge clk or negedge rstn[1]) if (!rstn[1]) model_reset(1); else model_step(1);

  // monitor: per-cycle status against the model, dispatches against the queue
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int occ;
      exp_t e;
      occ = 0;
      for (int i = 0; i < N; i++) occ += mv[k][i];
      check(k, "out_valid", int'(ov[k]), mov[k]);
      check(k, "now", int'(nw[k]), mnow[k]);
      check(k, "count", int'(cnt[k]), occ);
      check(k, "full", int'(fl[k]), int'(occ == N));
      check(k, "empty", int'(em[k]), int'(occ == 0));
      check(k, "in_ready", int'(irdy[k]), int'(occ != N));
      if (mov[k] != 0) check(k, "out_late", int'(olate[k]), int'(sdist(k, mnow[k], modl[k]) > 1));
      if (ov[k] && ordy[k]) begin
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          check(k, "unexpected_dispatch", int'(oid[k]), -1);
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          check(k, "out_id", int'(oid[k]), e.id);
          check(k, "out_deadline", int'(odl[k]), e.dl);
          if (k == 1) log1.push_back(int'(oid[k]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(int k);
    rstn[k] = 1'b0; iv[k] = 1'b0;
    tick();
    rstn[k] = 1'b1;
  endtask

  task automatic offer(int k, int id, int dl);
    iv[k] = 1'b1; iid[k] = 8'(id);
    idl[k] = (k == 0) ? 12'(dl) : 12'(dl & 32'h7F);
  endtask

  task automatic expect_out(int k, int id, int dl, int t);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!ov[k] && n < 200);
    check(k, "wait_out_valid", int'(ov[k]), 1);
    check(k, "dispatch_now", int'(nw[k]), t);
    check(k, "dispatch_id", int'(oid[k]), id);
    check(k, "dispatch_deadline", int'(odl[k]), dl);
  endtask

  task automatic wait_log(int n);
    for (int c = 0; c < 300 && log1.size() < n; c++) tick();
    check(1, "log_size", log1.size(), n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rdy_prev;
    tick();
    rstn = 2'b11;

    // release mode: id 6 (abs 5) then id 5 (abs 11)
    ordy[0] = 1'b1;
    do_reset(0);
    offer(0, 5, 10); tick(); offer(0, 6, 3); tick(); iv[0] = 1'b0;
    expect_out(0, 6, 5, 6);
    check(0, "late_at_6", int'(olate[0]), 0);
    expect_out(0, 5, 11, 12);

    // backpressure: id 6 held, late from now=7, taken at now=9
    ordy[0] = 1'b0;
    do_reset(0);
    offer(0, 5, 10); tick(); offer(0, 6, 3); tick(); iv[0] = 1'b0;
    expect_out(0, 6, 5, 6);
    check(0, "bp_late_at_6", int'(olate[0]), 0);
    for (int t = 7; t <= 9; t++) begin
      tick();
      if (t == 9) ordy[0] = 1'b1;
      @(negedge clk);
      check(0, "bp_held_valid", int'(ov[0]), 1);
      check(0, "bp_held_id", int'(oid[0]), 6);
      check(0, "bp_late", int'(olate[0]), 1);
    end
    expect_out(0, 5, 11, 12);

    // full: eight tasks, a ninth waits for the first dispatch
    ordy[0] = 1'b1;
    do_reset(0);
    for (int i = 0; i < 8; i++) begin offer(0, 10 + i, 100); tick(); end
    offer(0, 99, 5);
    @(negedge clk);
    check(0, "full_flag", int'(fl[0]), 1);
    check(0, "full_in_ready", int'(irdy[0]), 0);
    expect_out(0, 10, 101, 102);
    check(0, "ready_after_dispatch", int'(irdy[0]), 1);
    check(0, "count_after_dispatch", int'(cnt[0]), 7);
    tick(); iv[0] = 1'b0;
    @(negedge clk);
    check(0, "count_accept_and_load", int'(cnt[0]), 7);
    for (int c = 0; c < 300 && !(em[0] && !ov[0]); c++) tick();
    check(0, "full_drained", int'(em[0] && !ov[0]), 1);

    // reset mid-traffic
    ordy[0] = 1'b0;
    do_reset(0);
    offer(0, 20, 0); tick();
    for (int i = 1; i <= 3; i++) begin offer(0, 20 + i, 50); tick(); end
    iv[0] = 1'b0;
    @(negedge clk);
    check(0, "pre_reset_valid", int'(ov[0]), 1);
    check(0, "pre_reset_count", int'(cnt[0]), 3);
    #1 rstn[0] = 1'b0;
    #1;
    check(0, "rst_out_valid", int'(ov[0]), 0);
    check(0, "rst_out_id", int'(oid[0]), 0);
    check(0, "rst_out_deadline", int'(odl[0]), 0);
    check(0, "rst_out_late", int'(olate[0]), 0);
    check(0, "rst_count", int'(cnt[0]), 0);
    check(0, "rst_full", int'(fl[0]), 0);
    check(0, "rst_empty", int'(em[0]), 1);
    check(0, "rst_now", int'(nw[0]), 0);
    check(0, "rst_in_ready", int'(irdy[0]), 1);
    tick(); rstn[0] = 1'b1; ordy[0] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      check(0, "post_reset_no_dispatch", int'(ov[0]), 0);
    end

    // work-conserving order with a tie on absolute deadline
    ordy[1] = 1'b0;
    do_reset(1);
    log1.delete();
    offer(1, 0, 0); tick(); iv[1] = 1'b0; tick();
    offer(1, 1, 20); tick(); offer(1, 2, 19); tick(); offer(1, 3, 7); tick();
    iv[1] = 1'b0; ordy[1] = 1'b1;
    wait_log(4);
    if (log1.size() == 4) begin
      check(1, "order_0", log1[0], 0);
      check(1, "order_1", log1[1], 3);
      check(1, "order_2", log1[2], 1);
      check(1, "order_3", log1[3], 2);
    end

    // wrap-around: B (abs 252) ahead of A (abs 5)
    ordy[1] = 1'b0;
    do_reset(1);
    log1.delete();
    for (int c = 0; c < 300 && nw[1] != 16'd249; c++) tick();
    check(1, "reach_249", int'(nw[1]), 249);
    offer(1, 80, 0); tick();
    offer(1, 10, 10); tick();
    offer(1, 11, 0); tick();
    iv[1] = 1'b0; tick();
    ordy[1] = 1'b1;
    wait_log(3);
    if (log1.size() == 3) begin
      check(1, "wrap_0", log1[0], 80);
      check(1, "wrap_1", log1[1], 11);
      check(1, "wrap_2", log1[2], 10);
    end

    // randomized traffic on both instances
    do_reset(0);
    do_reset(1);
    rdy_prev = 2'b11;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!(iv[k] && !rdy_prev[k])) begin
          iv[k] = ($urandom_range(0, 1) == 1);
          offer(k, int'($urandom_range(0, 255)), int'($urandom_range(0, 30)));
          iv[k] = ($urandom_range(0, 1) == 1);
        end
        ordy[k] = ($urandom_range(0, 3) != 0);
      end
      rdy_prev = irdy;
      tick();
    end
    iv = 2'b00; ordy = 2'b11;
    for (int c = 0; c < 100; c++) tick();
    check(0, "queue_drained", q0.size(), 0);
    check(1, "queue_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
